// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: opcodes, FSM state encoding, CC encoding and sign-extension helpers.
package lc3_pkg;

    localparam logic [3:0] OpBr   = 4'b0000;
    localparam logic [3:0] OpAdd  = 4'b0001;
    localparam logic [3:0] OpLd   = 4'b0010;
    localparam logic [3:0] OpSt   = 4'b0011;
    localparam logic [3:0] OpJsr  = 4'b0100;
    localparam logic [3:0] OpAnd  = 4'b0101;
    localparam logic [3:0] OpLdr  = 4'b0110;
    localparam logic [3:0] OpStr  = 4'b0111;
    localparam logic [3:0] OpRti  = 4'b1000;
    localparam logic [3:0] OpNot  = 4'b1001;
    localparam logic [3:0] OpLdi  = 4'b1010;
    localparam logic [3:0] OpSti  = 4'b1011;
    localparam logic [3:0] OpJmp  = 4'b1100;
    localparam logic [3:0] OpRsv  = 4'b1101;
    localparam logic [3:0] OpLea  = 4'b1110;
    localparam logic [3:0] OpTrap = 4'b1111;

    localparam logic [2:0] CcN     = 3'b100;
    localparam logic [2:0] CcZ     = 3'b010;
    localparam logic [2:0] CcP     = 3'b001;
    localparam logic [2:0] CcReset = CcZ;

    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StExec, StInd, StMem, StHalted, StFault
    } state_e;

    function automatic logic [15:0] sext5(input logic [4:0] v);
        return {{11{v[4]}}, v};
    endfunction

    function automatic logic [15:0] sext6(input logic [5:0] v);
        return {{10{v[5]}}, v};
    endfunction

    function automatic logic [15:0] sext9(input logic [8:0] v);
        return {{7{v[8]}}, v};
    endfunction

    function automatic logic [15:0] sext11(input logic [10:0] v);
        return {{5{v[10]}}, v};
    endfunction

    function automatic logic [2:0] cc_of(input logic [15:0] v);
        if (v[15]) return CcN;
        if (v == 16'd0) return CcZ;
        return CcP;
    endfunction

endpackage

// File: rtl/lc3_multicycle_core_regfile.sv
// LC-3 register file: 8x16, two read ports plus a debug read port, one synchronous write port.
module lc3_regfile (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [2:0]  i_ra_sel,
    input  logic [2:0]  i_rb_sel,
    input  logic [2:0]  i_dbg_sel,
    input  logic        i_we,
    input  logic [2:0]  i_wsel,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_ra,
    output logic [15:0] o_rb,
    output logic [15:0] o_dbg
);

    logic [15:0] r_regs [8];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 8; i++) r_regs[i] <= 16'd0;
        end else if (i_we) begin
            r_regs[i_wsel] <= i_wdata;
        end
    end

    assign o_ra  = r_regs[i_ra_sel];
    assign o_rb  = r_regs[i_rb_sel];
    assign o_dbg = r_regs[i_dbg_sel];

endmodule

// File: rtl/lc3_multicycle_core.sv
// Multicycle LC-3 core: FSM and datapath driving a variable-latency req/ack memory port.
module lc3_multicycle_core
    import lc3_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned CNT_W    = 9,
    parameter logic [15:0] RESET_PC = 16'h0200,
    parameter logic [7:0]  HALT_VEC = 8'h25
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [15:0]       start_pc,
    input  logic              stop,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              running,
    output logic              halted,
    output logic              fault,
    output logic [15:0]       pc,
    output logic [15:0]       ir,
    output logic [2:0]        cc,
    output logic [CNT_W-1:0]  ins_cnt,
    input  logic [2:0]        dbg_sel,
    output logic [15:0]       dbg_reg
);

    state_e             r_state, w_state_nx;
    logic [15:0]        r_pc, w_pc_nx, r_ir, w_ir_nx;
    logic [2:0]         r_cc, w_cc_nx;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
    logic [ADDR_W-1:0]  r_ea, w_ea_nx;

    logic [3:0]  w_op;
    logic [2:0]  w_dr, w_rb_sel, w_rf_wsel;
    logic [15:0] w_ra, w_rb, w_opb, w_alu, w_ea, w_rf_wdata;
    logic        w_rf_we, w_ea_go, w_retire, w_trap_halt, w_is_load, w_is_store;

    function automatic logic in_range(input logic [15:0] a);
        return (a >> ADDR_W) == 16'd0;
    endfunction

    assign w_op       = r_ir[15:12];
    assign w_dr       = r_ir[11:9];
    assign w_rb_sel   = (r_state == StMem) ? w_dr : r_ir[2:0];
    assign w_is_load  = (w_op == OpLd) || (w_op == OpLdr) || (w_op == OpLdi);
    assign w_is_store = (w_op == OpSt) || (w_op == OpStr) || (w_op == OpSti);

    lc3_regfile u_regfile (
        .i_clk     (CLK),
        .i_rst     (RST),
        .i_ra_sel  (r_ir[8:6]),
        .i_rb_sel  (w_rb_sel),
        .i_dbg_sel (dbg_sel),
        .i_we      (w_rf_we),
        .i_wsel    (w_rf_wsel),
        .i_wdata   (w_rf_wdata),
        .o_ra      (w_ra),
        .o_rb      (w_rb),
        .o_dbg     (dbg_reg)
    );

    always_comb begin
        w_opb = r_ir[5] ? sext5(r_ir[4:0]) : w_rb;
        case (w_op)
            OpAdd:   w_alu = w_ra + w_opb;
            OpAnd:   w_alu = w_ra & w_opb;
            OpNot:   w_alu = ~w_ra;
            default: w_alu = r_pc + sext9(r_ir[8:0]);
        endcase
    end

    // Bus outputs are decoded from registered state, so they hold steady while waiting for ack.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 16'd0;
        unique case (r_state)
            StFetch: begin
                if (in_range(r_pc)) begin
                    mem_req  = 1'b1;
                    mem_addr = r_pc[ADDR_W-1:0];
                end
            end
            StInd: begin
                mem_req  = 1'b1;
                mem_addr = r_ea;
            end
            StMem: begin
                mem_req  = 1'b1;
                mem_addr = r_ea;
                if (w_is_store) begin
                    mem_we    = 1'b1;
                    mem_wdata = w_rb;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nx  = r_state;
        w_pc_nx     = r_pc;
        w_ir_nx     = r_ir;
        w_cc_nx     = r_cc;
        w_cnt_nx    = r_cnt;
        w_ea_nx     = r_ea;
        w_rf_we     = 1'b0;
        w_rf_wsel   = w_dr;
        w_rf_wdata  = 16'd0;
        w_ea        = 16'd0;
        w_ea_go     = 1'b0;
        w_retire    = 1'b0;
        w_trap_halt = 1'b0;
        unique case (r_state)
            StIdle, StHalted, StFault: begin
                if (start) begin
                    w_pc_nx    = start_pc;
                    w_cnt_nx   = '0;
                    w_state_nx = StFetch;
                end
            end
            StFetch: begin
                if (!in_range(r_pc)) begin
                    w_state_nx = StFault;
                end else if (mem_ack) begin
                    w_ir_nx    = mem_rdata;
                    w_pc_nx    = r_pc + 16'd1;
                    w_state_nx = StDecode;
                end
            end
            StDecode: begin
                // pc is rewound so HALTED/FAULT point at the discarded or faulting instruction.
                if (stop) begin
                    w_pc_nx    = r_pc - 16'd1;
                    w_state_nx = StHalted;
                end else if (w_op == OpRti || w_op == OpRsv) begin
                    w_pc_nx    = r_pc - 16'd1;
                    w_state_nx = StFault;
                end else begin
                    w_state_nx = StExec;
                end
            end
            StExec: begin
                case (w_op)
                    OpAdd, OpAnd, OpNot, OpLea: begin
                        w_rf_we    = 1'b1;
                        w_rf_wdata = w_alu;
                        w_cc_nx    = cc_of(w_alu);
                        w_retire   = 1'b1;
                    end
                    OpBr: begin
                        if ((r_ir[11:9] & r_cc) != 3'b000) w_pc_nx = r_pc + sext9(r_ir[8:0]);
                        w_retire = 1'b1;
                    end
                    OpJmp: begin
                        w_pc_nx  = w_ra;
                        w_retire = 1'b1;
                    end
                    OpJsr: begin
                        w_rf_we    = 1'b1;
                        w_rf_wsel  = 3'd7;
                        w_rf_wdata = r_pc;
                        w_pc_nx    = r_ir[11] ? r_pc + sext11(r_ir[10:0]) : w_ra;
                        w_retire   = 1'b1;
                    end
                    OpLd, OpSt, OpLdi, OpSti: begin
                        w_ea    = r_pc + sext9(r_ir[8:0]);
                        w_ea_go = 1'b1;
                    end
                    OpLdr, OpStr: begin
                        w_ea    = w_ra + sext6(r_ir[5:0]);
                        w_ea_go = 1'b1;
                    end
                    OpTrap: begin
                        if (r_ir[7:0] == HALT_VEC) begin
                            w_rf_we     = 1'b1;
                            w_rf_wsel   = 3'd7;
                            w_rf_wdata  = r_pc;
                            w_retire    = 1'b1;
                            w_trap_halt = 1'b1;
                        end else begin
                            w_ea    = {8'd0, r_ir[7:0]};
                            w_ea_go = 1'b1;
                        end
                    end
                    default: begin
                        w_pc_nx    = r_pc - 16'd1;
                        w_state_nx = StFault;
                    end
                endcase
                if (w_ea_go) begin
                    if (in_range(w_ea)) begin
                        w_ea_nx    = w_ea[ADDR_W-1:0];
                        w_state_nx = (w_op == OpLdi || w_op == OpSti) ? StInd : StMem;
                    end else begin
                        w_pc_nx    = r_pc - 16'd1;
                        w_state_nx = StFault;
                    end
                end
            end
            StInd: begin
                if (mem_ack) begin
                    if (in_range(mem_rdata)) begin
                        w_ea_nx    = mem_rdata[ADDR_W-1:0];
                        w_state_nx = StMem;
                    end else begin
                        w_pc_nx    = r_pc - 16'd1;
                        w_state_nx = StFault;
                    end
                end
            end
            StMem: begin
                if (mem_ack) begin
                    if (w_is_load) begin
                        w_rf_we    = 1'b1;
                        w_rf_wdata = mem_rdata;
                        w_cc_nx    = cc_of(mem_rdata);
                    end else if (w_op == OpTrap) begin
                        w_rf_we    = 1'b1;
                        w_rf_wsel  = 3'd7;
                        w_rf_wdata = r_pc;
                        w_pc_nx    = mem_rdata;
                    end
                    w_retire = 1'b1;
                end
            end
            default: w_state_nx = StIdle;
        endcase
        if (w_retire) begin
            if (r_cnt != {CNT_W{1'b1}}) w_cnt_nx = r_cnt + 1'b1;
            w_state_nx = (stop || w_trap_halt) ? StHalted : StFetch;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= StIdle;
            r_pc    <= RESET_PC;
            r_ir    <= 16'd0;
            r_cc    <= CcReset;
            r_cnt   <= '0;
            r_ea    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_pc    <= w_pc_nx;
            r_ir    <= w_ir_nx;
            r_cc    <= w_cc_nx;
            r_cnt   <= w_cnt_nx;
            r_ea    <= w_ea_nx;
        end
    end

    assign running = !(r_state == StIdle || r_state == StHalted || r_state == StFault);
    assign halted  = (r_state == StHalted);
    assign fault   = (r_state == StFault);
    assign pc      = r_pc;
    assign ir      = r_ir;
    assign cc      = r_cc;
    assign ins_cnt = r_cnt;

endmodule

// File: tb/tb_lc3_multicycle_core.sv
// Directed bench for lc3_multicycle_core: single-instruction vector table plus multi-cycle sequences.
module tb_lc3_multicycle_core;

    logic        clk = 1'b0;
    logic        rst, start, stop;
    logic [15:0] start_pc;
    logic        mem_req, mem_we, mem_ack;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        running, halted, fault;
    logic [15:0] pc, ir, dbg_reg;
    logic [2:0]  cc, dbg_sel;
    logic [8:0]  ins_cnt;

    always #5 clk = ~clk;

    lc3_multicycle_core dut (
        .CLK       (clk),
        .RST       (rst),
        .start     (start),
        .start_pc  (start_pc),
        .stop      (stop),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .running   (running),
        .halted    (halted),
        .fault     (fault),
        .pc        (pc),
        .ir        (ir),
        .cc        (cc),
        .ins_cnt   (ins_cnt),
        .dbg_sel   (dbg_sel),
        .dbg_reg   (dbg_reg)
    );

    // Memory model with programmable wait states and a backdoor load port.
    logic [15:0] mem [0:1023];
    int unsigned wait_cfg = 0, wcnt = 0, wr_cnt = 0, req_cyc = 0, stab_viol = 0;
    logic        bd_we;
    logic [9:0]  bd_addr;
    logic [15:0] bd_data;
    logic        p_wait = 1'b0, p_we = 1'b0;
    logic [9:0]  p_addr = '0;
    logic [15:0] p_wdata = '0;

    assign mem_ack   = mem_req && (wcnt >= wait_cfg);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 16'd0;
        end else begin
            if (bd_we) mem[bd_addr] <= bd_data;
            if (mem_req && mem_ack && mem_we) begin
                mem[mem_addr] <= mem_wdata;
                wr_cnt <= wr_cnt + 1;
            end
        end
        if (mem_req) req_cyc <= req_cyc + 1;
        wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;
        if (p_wait && (!mem_req || mem_we != p_we || mem_addr != p_addr || mem_wdata != p_wdata))
            stab_viol <= stab_viol + 1;
        p_wait  <= mem_req && !mem_ack && !rst;
        p_we    <= mem_we;
        p_addr  <= mem_addr;
        p_wdata <= mem_wdata;
    end

    int n_chk = 0, n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [9:0] a, input logic [15:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic reg_is(input string name, input logic [2:0] sel, input logic [15:0] exp);
        dbg_sel = sel; #1;
        check(name, 32'(dbg_reg), 32'(exp));
    endtask

    // Cycles are counted from the start edge to the edge that leaves the running states.
    task automatic run(input logic [15:0] spc, output int cyc);
        start_pc = spc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (running && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("run_finished", 32'(running), 32'd0);
    endtask

    typedef struct {
        logic [15:0] instr;
        int unsigned waits;
        logic [2:0]  sel;
        logic [15:0] val;
        logic [2:0]  ccx;
        int          cycles;
        logic        chk_mem;
        logic [9:0]  maddr;
        logic [15:0] mval;
    } vec_t;

    vec_t vecs [13];
    int cyc;
    int unsigned snap;

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; start_pc = 16'd0; dbg_sel = 3'd0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;

        // Registers carry over between rows; R0=FFFF and R7=0203 on entry.
        vecs[0]  = '{16'h1221, 0, 3'd1, 16'h0000, 3'b010, 6, 1'b0, 10'h000, 16'h0000};
        vecs[1]  = '{16'h1400, 0, 3'd2, 16'hFFFE, 3'b100, 6, 1'b0, 10'h000, 16'h0000};
        vecs[2]  = '{16'h96BF, 0, 3'd3, 16'h0001, 3'b001, 6, 1'b0, 10'h000, 16'h0000};
        vecs[3]  = '{16'h5830, 0, 3'd4, 16'hFFF0, 3'b100, 6, 1'b0, 10'h000, 16'h0000};
        vecs[4]  = '{16'hEA4F, 0, 3'd5, 16'h0250, 3'b001, 6, 1'b0, 10'h000, 16'h0000};
        vecs[5]  = '{16'h6D40, 0, 3'd6, 16'h1234, 3'b001, 7, 1'b0, 10'h000, 16'h0000};
        vecs[6]  = '{16'h23FE, 0, 3'd1, 16'h7FFF, 3'b001, 7, 1'b0, 10'h000, 16'h0000};
        vecs[7]  = '{16'h3DFD, 0, 3'd6, 16'h1234, 3'b001, 7, 1'b1, 10'h1FE, 16'h1234};
        vecs[8]  = '{16'h7741, 0, 3'd3, 16'h0001, 3'b001, 7, 1'b1, 10'h251, 16'h0001};
        vecs[9]  = '{16'h927F, 0, 3'd1, 16'h8000, 3'b100, 6, 1'b0, 10'h000, 16'h0000};
        vecs[10] = '{16'h7142, 0, 3'd0, 16'hFFFF, 3'b100, 7, 1'b1, 10'h252, 16'hFFFF};
        vecs[11] = '{16'h16EF, 2, 3'd3, 16'h0010, 3'b001, 10, 1'b0, 10'h000, 16'h0000};
        vecs[12] = '{16'h29FE, 1, 3'd4, 16'h7FFF, 3'b001, 10, 1'b0, 10'h000, 16'h0000};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_pc", 32'(pc), 32'h0200);
        check("rst_cc", 32'(cc), 32'b010);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_cnt", 32'(ins_cnt), 32'd0);
        check("rst_idle", 32'({running, halted, fault}), 32'd0);
        for (int i = 0; i < 8; i++) reg_is("rst_dbg", 3'(i), 16'h0000);

        // AND/ADD/HALT, zero-wait then 3 wait states per access.
        poke(10'h200, 16'h5020); poke(10'h201, 16'h103F); poke(10'h202, 16'hF025);
        for (int w = 0; w < 2; w++) begin
            wait_cfg = (w == 0) ? 0 : 3;
            snap = req_cyc;
            run(16'h0200, cyc);
            check("p1_cycles", 32'(cyc), (w == 0) ? 32'd9 : 32'd18);
            check("p1_req_cycles", req_cyc - snap, (w == 0) ? 32'd3 : 32'd12);
            check("p1_halted", 32'(halted), 32'd1);
            check("p1_cc", 32'(cc), 32'b100);
            check("p1_cnt", 32'(ins_cnt), 32'd3);
            reg_is("p1_r0", 3'd0, 16'hFFFF);
            reg_is("p1_r7", 3'd7, 16'h0203);
        end
        check("handshake_stable", stab_viol, 32'd0);
        wait_cfg = 0;

        poke(10'h250, 16'h1234); poke(10'h1FF, 16'h7FFF); poke(10'h201, 16'hF025);
        for (int i = 0; i < 13; i++) begin
            poke(10'h200, vecs[i].instr);
            wait_cfg = vecs[i].waits;
            run(16'h0200, cyc);
            check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].cycles));
            check($sformatf("vec%0d_cnt", i), 32'(ins_cnt), 32'd2);
            check($sformatf("vec%0d_cc", i), 32'(cc), 32'(vecs[i].ccx));
            reg_is($sformatf("vec%0d_reg", i), vecs[i].sel, vecs[i].val);
            if (vecs[i].chk_mem)
                check($sformatf("vec%0d_mem", i), 32'(mem[vecs[i].maddr]), 32'(vecs[i].mval));
        end
        check("handshake_stable2", stab_viol, 32'd0);
        wait_cfg = 0;

        // LDI R1 via 0x210, STI R1 via 0x211.
        poke(10'h210, 16'h0300); poke(10'h300, 16'h8001); poke(10'h211, 16'h0301);
        poke(10'h200, 16'hA20F); poke(10'h201, 16'hB20F); poke(10'h202, 16'hF025);
        snap = wr_cnt;
        run(16'h0200, cyc);
        check("ind_cycles", 32'(cyc), 32'd13);
        reg_is("ind_r1", 3'd1, 16'h8001);
        check("ind_cc", 32'(cc), 32'b100);
        check("ind_mem", 32'(mem[10'h301]), 32'h8001);
        check("ind_writes", wr_cnt - snap, 32'd1);
        check("ind_cnt", 32'(ins_cnt), 32'd3);

        // BRn not taken on Z, taken on N; a wrong path loops or faults.
        poke(10'h200, 16'h54A0); poke(10'h201, 16'h09FE); poke(10'h202, 16'h14BF);
        poke(10'h203, 16'h0E01); poke(10'h204, 16'hF025); poke(10'h205, 16'h09FE);
        poke(10'h206, 16'hD000);
        run(16'h0200, cyc);
        check("br_halted", 32'(halted), 32'd1);
        check("br_pc", 32'(pc), 32'h0205);
        check("br_cnt", 32'(ins_cnt), 32'd6);
        check("br_cycles", 32'(cyc), 32'd18);

        // LEA R7; JSRR R7; capture R7; JSR +2; TRAP x30 -> 0x220; capture R7; HALT.
        poke(10'h200, 16'hEE10); poke(10'h201, 16'h41C0); poke(10'h211, 16'h1DE0);
        poke(10'h212, 16'h4802); poke(10'h215, 16'hF030); poke(10'h030, 16'h0220);
        poke(10'h220, 16'h1BE0); poke(10'h221, 16'hF025);
        run(16'h0200, cyc);
        reg_is("jsrr_ret", 3'd6, 16'h0202);
        reg_is("trap_ret", 3'd5, 16'h0216);
        reg_is("halt_r7", 3'd7, 16'h0222);
        check("jsr_pc", 32'(pc), 32'h0222);
        check("jsr_cnt", 32'(ins_cnt), 32'd7);
        check("jsr_cycles", 32'(cyc), 32'd22);

        // stop held across start: first instruction discarded at DECODE.
        stop = 1'b1;
        run(16'h0200, cyc);
        stop = 1'b0;
        check("stop_cycles", 32'(cyc), 32'd2);
        check("stop_halted", 32'(halted), 32'd1);
        check("stop_pc", 32'(pc), 32'h0200);
        check("stop_cnt", 32'(ins_cnt), 32'd0);
        reg_is("stop_r7", 3'd7, 16'h0222);

        // Reserved opcode after one retired ADD.
        poke(10'h200, 16'h1020); poke(10'h201, 16'hD000);
        snap = req_cyc;
        run(16'h0200, cyc);
        repeat (4) @(posedge clk);
        #1;
        check("rsv_fault", 32'(fault), 32'd1);
        check("rsv_pc", 32'(pc), 32'h0201);
        check("rsv_ir", 32'(ir), 32'hD000);
        check("rsv_cnt", 32'(ins_cnt), 32'd1);
        check("rsv_reqs", req_cyc - snap, 32'd2);

        // LD at 0x3FF with +5 lands at 0x405, beyond the 10-bit space.
        poke(10'h3FF, 16'h2205);
        snap = req_cyc;
        run(16'h03FF, cyc);
        check("ea_fault", 32'(fault), 32'd1);
        check("ea_pc", 32'(pc), 32'h03FF);
        check("ea_ir", 32'(ir), 32'h2205);
        check("ea_reqs", req_cyc - snap, 32'd1);
        check("ea_cnt", 32'(ins_cnt), 32'd0);
        check("ea_cc", 32'(cc), 32'b100);
        reg_is("ea_r1", 3'd1, 16'h8001);

        snap = req_cyc;
        run(16'h0400, cyc);
        check("fetch_fault", 32'(fault), 32'd1);
        check("fetch_reqs", req_cyc - snap, 32'd0);
        check("fetch_pc", 32'(pc), 32'h0400);

        poke(10'h200, 16'hF025);
        run(16'h0200, cyc);
        check("resume_halted", 32'({halted, fault}), 32'b10);
        check("resume_cnt", 32'(ins_cnt), 32'd1);
        check("resume_pc", 32'(pc), 32'h0201);

        // Reset while a fetch is waiting for ack.
        wait_cfg = 5;
        start_pc = 16'h0200; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("midrst_req_before", 32'({mem_req, mem_addr}), 32'({1'b1, 10'h200}));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_req_after", 32'(mem_req), 32'd0);
        check("midrst_idle", 32'(running), 32'd0);
        check("midrst_pc", 32'(pc), 32'h0200);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/lc3_multicycle_core.md
# lc3_multicycle_core

Parametrised multicycle LC-3 execution core with a variable-latency req/ack memory port, explicit HALT/FAULT states and debug visibility. It replaces the fixed-timing core embedded in the board top level. The board top level keeps the button/SW front end, display and memory macro, and drives this core through start/stop. The core executes the full LC-3 user ISA except RTI, with correct CC, PC-relative and sign-extension semantics.

## Interface
- ADDR_W, 10: memory word-address width (1..16); accesses at or above 2^ADDR_W fault.
- CNT_W, 9: retired-instruction counter width.
- RESET_PC, 16'h0200: PC value after reset.
- HALT_VEC, 8'h25: TRAP vector treated as HALT (no memory access).

Ports:
- CLK  in  1  core clock; everything is sampled on the rising edge.
- RST  in  1  reset; synchronous and active-high.
- start  in  1  one-cycle pulse that begins execution at start_pc. Honoured only in IDLE, HALTED or FAULT.
- start_pc  in  16  entry PC.
- stop  in  1  level; requests halt at the next instruction boundary.
- mem_req  out  1  memory request.
- mem_we  out  1  write request; qualified by mem_req.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  16  write data.
- mem_rdata  in  16  read data; valid in the cycle mem_ack=1.
- mem_ack  in  1  access complete.
- running  out  1  state is neither IDLE, HALTED nor FAULT.
- halted  out  1  state == HALTED.
- fault  out  1  state == FAULT.
- pc, ir  out  16  architectural PC and instruction register.
- cc  out  3  N, Z, P flags.
- ins_cnt  out  CNT_W  retired-instruction count.
- dbg_sel  in  3  register-file debug select.
- dbg_reg  out  16  R[dbg_sel], combinational.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, IND, MEM, HALTED, FAULT.
- Reset values:
  - state=IDLE, pc=RESET_PC, ir=0, R0..R7=0, cc=3'b010, ins_cnt=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- FETCH: drive mem_addr=pc[ADDR_W-1:0] with mem_req=1. On ack: ir<=mem_rdata, pc<=pc+1, go to DECODE. If pc>=2^ADDR_W, go to FAULT with no request.
- DECODE:
  - If stop=1, the fetched instruction is discarded; pc is restored to pc-1 and the state goes to HALTED.
  - Opcodes 1000 (RTI) and 1101 go to FAULT.
  - Otherwise go to EXEC.
- EXEC:
  - ADD, AND, NOT, LEA: write DR, set cc, retire.
  - BR: if (n&N)|(z&Z)|(p&P), pc<=pc+SEXT(PCoffset9); retire.
  - JMP/RET: pc<=R[BaseR]; retire.
  - JSR/JSRR: read the target first, then R7<=pc, then pc<=pc+SEXT(PCoffset11) or the old R[BaseR]; retire. JSRR R7 is correct.
  - LD, ST, LDR, STR: compute EA (PCoffset9 or BaseR+SEXT(offset6)), then go to MEM.
  - LDI, STI: compute the pointer address, then go to IND.
  - TRAP:
    - If trapvect8==HALT_VEC: R7<=pc; retire; go to HALTED.
    - Otherwise: MEM reads the word at ZEXT(trapvect8), then R7<=pc and pc<=mem_rdata; retire.
- Every EA is computed in 16 bits. If EA>=2^ADDR_W, go to FAULT with no request and no architectural update.
- IND: read the pointer. On ack, EA<=mem_rdata (range-checked as above), then go to MEM.
- MEM:
  - Loads on ack: DR<=mem_rdata and set cc.
  - Stores: mem_we=1, mem_wdata=R[SR]; cc is unchanged.
  - Retire on ack.
- cc is updated only by ADD, AND, NOT, LD, LDR, LDI and LEA.
  - N = bit 15 of the written value; Z = value==0; P = otherwise.
  - Exactly one flag is set at all times.
- Retire: ins_cnt increments, saturating at all-ones. The next state is HALTED if stop=1, otherwise FETCH.
- FAULT leaves ir and pc at the faulting instruction; ins_cnt does not increment.
- start in IDLE, HALTED or FAULT: pc<=start_pc, ins_cnt<=0, go to FETCH. Registers and cc are preserved. start is ignored while running.

## Timing
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable from assertion until the cycle mem_ack=1 is sampled. mem_req deasserts the following cycle unless a new access begins.
  - Zero-wait ack is legal: ack in the same cycle req is asserted, so one access costs one cycle.
  - mem_ack while mem_req=0 is ignored.
- Zero-wait cycle counts from FETCH entry to retirement:
  - ALU, BR, JMP, JSR, LEA, TRAP-HALT: 3.
  - LD, ST, LDR, STR, TRAP: 4.
  - LDI, STI: 5.
- Each wait cycle on an access adds exactly one cycle.
- RST mid-access: mem_req drops the next cycle. Any outstanding ack is then ignored.
- stop takes effect only at an instruction boundary. It never truncates an access.

## Structure
- lc3_pkg holds:
  - opcode constants;
  - the state encoding;
  - sext9/sext11/sext6 helper functions;
  - the cc encoding constants and the reset CC value.
- Sub-module lc3_regfile: 8x16 registers, two read ports plus the dbg port, one synchronous write port, cleared on RST.
- The main FSM and datapath live in lc3_multicycle_core.

## Test plan
- Reset: assert RST 2 cycles -> pc=0x0200, cc=010, mem_req=0, ins_cnt=0, state IDLE, dbg_reg=0 for all selects.
- Program at 0x0200 {0x5020, 0x103F, 0xF025}, start_pc=0x0200, zero-wait -> R0=0xFFFF, cc=100, R7=0x0203, halted=1, ins_cnt=3, total 9 cycles from start.
- Same program with ack delayed 3 cycles per access -> mem_addr/mem_req stable while waiting, identical final state, 18 cycles.
- LDI/STI: mem[0x210]=0x0300, mem[0x300]=0x8001; LDI R1 and STI R1 through 0x211=0x0301 -> R1=0x8001, cc=100, mem[0x301]=0x8001, exactly one write.
- Branch/JSRR: BRn -2 taken when N, not taken when Z; JSRR R7 -> pc = old R7, R7 = return address.
- Faults: 0xD000 -> fault=1, ins_cnt unchanged, no extra mem_req. LD at 0x03FF with offset +5 (ADDR_W=10) -> fault, no request. Then start -> resumes cleanly.
